// File: rtl/mul_div_unit.sv
// Multicycle signed/unsigned multiply-divide engine writing HI/LO.
// Booth multiplier and restoring divider share one accumulator/shift datapath.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [CNT_W-1:0] counter
);

  localparam int AW = WIDTH + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FINISH,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    m_q, m_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic             qm1_q, qm1_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_signed;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [AW-1:0]    booth_sum;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] q_fix, r_fix, mul_hi;

  assign in_signed = ~op[0];
  assign a_mag = (in_signed & a[WIDTH-1]) ? -a : a;
  assign b_mag = (in_signed & b[WIDTH-1]) ? -b : b;

  always_comb begin
    booth_sum = acc_q;
    case ({mq_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase
  end

  assign rem_sh  = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
  assign rem_sub = rem_sh - m_q[WIDTH:0];
  assign rem_ge  = (rem_sh >= m_q[WIDTH:0]);

  // Remainder follows the dividend sign: truncation toward zero.
  assign q_fix = (~op_q[0] & (sa_q ^ sb_q)) ? -mq_q : mq_q;
  assign r_fix = (~op_q[0] & sa_q) ? -acc_q[WIDTH-1:0]
                                   : acc_q[WIDTH-1:0];
  // Booth reads b as signed; unsigned b with MSB set needs +a<<WIDTH.
  assign mul_hi = acc_q[WIDTH-1:0] +
                  ((op_q[0] & sb_q) ? m_q[WIDTH-1:0] : '0);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    mq_d    = mq_q;
    qm1_d   = qm1_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          op_d  = op;
          sa_d  = a[WIDTH-1];
          sb_d  = b[WIDTH-1];
          dz_d  = 1'b0;
          acc_d = '0;
          qm1_d = 1'b0;
          if (op[1]) begin
            mq_d = a_mag;
            m_d  = {2'b00, b_mag};
            if (b == '0) begin
              dz_d    = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_DIV;
            end
          end else begin
            mq_d    = b;
            m_d     = op[0] ? {2'b00, a} : {{2{a[WIDTH-1]}}, a};
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == CNT_MAX) begin
          state_d = S_FINISH;
        end else begin
          acc_d = {booth_sum[AW-1], booth_sum[AW-1:1]};
          mq_d  = {booth_sum[0], mq_q[WIDTH-1:1]};
          qm1_d = mq_q[0];
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DIV: begin
        if (cnt_q == CNT_MAX) begin
          state_d = S_FINISH;
        end else begin
          acc_d = rem_ge ? {2'b00, rem_sub[WIDTH-1:0]}
                         : {2'b00, rem_sh[WIDTH-1:0]};
          mq_d  = {mq_q[WIDTH-2:0], rem_ge};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FINISH: begin
        hi_d    = op_q[1] ? r_fix : mul_hi;
        lo_d    = op_q[1] ? q_fix : mq_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      m_q     <= '0;
      mq_q    <= '0;
      qm1_q   <= 1'b0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      mq_q    <= mq_d;
      qm1_q   <= qm1_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == S_MUL) || (state_q == S_DIV) ||
                    (state_q == S_FINISH);
  assign done     = (state_q == S_DONE);
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign counter  = cnt_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32 and WIDTH=8.
// Each step drives one operation and checks hand-computed HI/LO/latency.
module tb_mul_div_unit;

  logic        clock = 1'b0;
  logic        rst   = 1'b0;
  logic        start32 = 1'b0;
  logic [1:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic [5:0]  cnt32;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;
  logic [3:0]  cnt8;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mul_div_unit #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(rst), .start(start32), .op(op32),
    .a(a32), .b(b32), .busy(busy32), .done(done32),
    .div_zero(dz32), .hi(hi32), .lo(lo32), .counter(cnt32)
  );

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(rst), .start(start8), .op(op8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .div_zero(dz8), .hi(hi8), .lo(lo8), .counter(cnt8)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run32(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int inj,
                       input int rst_at, output int n,
                       output logic bsy0, output logic dz0);
    op32 = o; a32 = x; b32 = y; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    op32 = ~o; a32 = $urandom; b32 = $urandom;
    bsy0 = busy32; dz0 = dz32; n = 0;
    while (!done32 && n < 200) begin
      if (n == inj) begin
        start32 = 1'b1; op32 = 2'b11; b32 = '0;
      end
      if (n == rst_at) rst = 1'b1;
      tick();
      n++;
      start32 = 1'b0;
      if (rst) begin
        rst = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle32(input string tag, input logic [31:0] eh,
                        input logic [31:0] el);
    tick();
    chk({tag, ".idle_busy"}, 64'(busy32), 64'd0);
    chk({tag, ".idle_done"}, 64'(done32), 64'd0);
    chk({tag, ".idle_cnt"}, 64'(cnt32), 64'd0);
    chk({tag, ".hold_hilo"}, {hi32, lo32}, {eh, el});
  endtask

  initial begin
    int   n;
    logic b0, z0;

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst.busy", 64'(busy32), 64'd0);
    chk("rst.done", 64'(done32), 64'd0);
    chk("rst.dz", 64'(dz32), 64'd0);
    chk("rst.hilo", {hi32, lo32}, 64'd0);
    chk("rst.cnt", 64'(cnt32), 64'd0);
    chk("rst8.hilo", 64'({hi8, lo8}), 64'd0);

    run32(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, -1, -1, n, b0, z0);
    chk("mult.busy0", 64'(b0), 64'd1);
    chk("mult.lat", 64'(n), 64'd34);
    chk("mult.hilo", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mult.cnt", 64'(cnt32), 64'd32);
    chk("mult.busy_done", 64'(busy32), 64'd0);
    idle32("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    run32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, n, b0, z0);
    chk("multu.lat", 64'(n), 64'd34);
    chk("multu.hilo", {hi32, lo32}, 64'hFFFF_FFFE_0000_0001);
    idle32("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    run32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, n, b0, z0);
    chk("mult_m1.hilo", {hi32, lo32}, 64'h0000_0000_0000_0001);
    idle32("mult_m1", 32'h0, 32'h1);

    run32(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, -1, -1, n, b0, z0);
    chk("div.lat", 64'(n), 64'd34);
    chk("div.hilo", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div.dz", 64'(dz32), 64'd0);
    idle32("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run32(2'b11, 32'h0000_0007, 32'h0000_0002, -1, -1, n, b0, z0);
    chk("divu.hilo", {hi32, lo32}, 64'h0000_0001_0000_0003);
    idle32("divu", 32'h1, 32'h3);

    run32(2'b11, 32'h0000_0007, 32'h0000_0000, -1, -1, n, b0, z0);
    chk("dz.lat", 64'(n), 64'd0);
    chk("dz.busy0", 64'(b0), 64'd0);
    chk("dz.flag", 64'(dz32), 64'd1);
    chk("dz.hilo", {hi32, lo32}, 64'h0000_0001_0000_0003);
    idle32("dz", 32'h1, 32'h3);
    chk("dz.flag_held", 64'(dz32), 64'd1);

    run32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, n, b0, z0);
    chk("ovf.dz_clr", 64'(z0), 64'd0);
    chk("ovf.lat", 64'(n), 64'd34);
    chk("ovf.hilo", {hi32, lo32}, 64'h0000_0000_8000_0000);
    chk("ovf.dz", 64'(dz32), 64'd0);
    idle32("ovf", 32'h0, 32'h8000_0000);

    run32(2'b00, 32'd5, 32'd6, 10, -1, n, b0, z0);
    chk("ign.lat", 64'(n), 64'd34);
    chk("ign.hilo", {hi32, lo32}, 64'd30);
    chk("ign.dz", 64'(dz32), 64'd0);
    idle32("ign", 32'h0, 32'd30);

    run32(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, -1, 15, n, b0, z0);
    chk("rstmid.n", 64'(n), 64'd16);
    chk("rstmid.busy", 64'(busy32), 64'd0);
    chk("rstmid.done", 64'(done32), 64'd0);
    chk("rstmid.hilo", {hi32, lo32}, 64'd0);
    chk("rstmid.cnt", 64'(cnt32), 64'd0);
    tick();
    chk("rstmid.stay_idle", 64'(busy32), 64'd0);

    run32(2'b01, 32'h0001_0000, 32'h0001_0000, -1, -1, n, b0, z0);
    chk("after_rst.lat", 64'(n), 64'd34);
    chk("after_rst.hilo", {hi32, lo32}, 64'h0000_0001_0000_0000);
    idle32("after_rst", 32'h1, 32'h0);

    op8 = 2'b00; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    n = 0;
    while (!done8 && n < 100) begin
      tick();
      n++;
    end
    chk("w8.lat", 64'(n), 64'd10);
    chk("w8.hilo", 64'({hi8, lo8}), 64'h4000);
    chk("w8.cnt", 64'(cnt8), 64'd8);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised multicycle integer multiply/divide engine that writes HI/LO.
- Successor to the fixed 32-bit separate multiplier and divider pair in the multicycle CPU.
- Merges both into one shared-datapath unit with a start/done handshake, a busy flag, signed and unsigned modes, and a configurable width.
- The control FSM issues start with an op code, then waits for done before reading hi/lo.

Parameters:
- WIDTH, 32, operand width in bits; hi and lo are each WIDTH bits; minimum 4.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter output.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin an operation; sampled only in IDLE.
- op  in  2  operation select: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
- a  in  WIDTH  multiplicand / dividend; latched on the accepted start.
- b  in  WIDTH  multiplier / divisor; latched on the accepted start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; hi, lo and div_zero are valid in that cycle and held afterwards.
- div_zero  out  1  set with done when a DIV/DIVU has divisor 0; cleared on the next accepted start.
- hi  out  WIDTH  MULT: upper product half. DIV: remainder.
- lo  out  WIDTH  MULT: lower product half. DIV: quotient.
- counter  out  CNT_W  iterations completed in the current operation; 0 in IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0. Reset wins over all other inputs in the same cycle.
- Reset mid-operation: the operation is discarded and the unit returns to IDLE with the reset values above.
- States: IDLE, MUL, DIV, FINISH, DONE.
- IDLE:
  - start=1 latches a, b and op.
  - Clears div_zero and counter.
  - DIV/DIVU with b==0 goes directly to DONE.
  - Otherwise MUL-type ops go to MUL and DIV-type ops go to DIV.
- MUL:
  - Radix-2 Booth iteration on a 2*WIDTH+1-bit product register.
  - Unsigned mode zero-extends the operands by one bit internally.
  - counter increments each cycle; at counter==WIDTH go to FINISH.
- DIV:
  - Restoring division on operand magnitudes; one quotient bit per cycle.
  - Signs are recorded at latch time.
  - counter increments each cycle; at counter==WIDTH go to FINISH.
- FINISH:
  - Applies sign correction for DIV: quotient negated if the operand signs differ; remainder takes the sign of the dividend (truncation toward zero).
  - Loads hi/lo; next state DONE.
- DONE:
  - done=1 for exactly this cycle, then IDLE.
  - hi/lo keep their values until the next operation's FINISH.
- Latency: start accepted at edge 0; done high in the cycle following edge WIDTH+2 (34 cycles for WIDTH=32).
- Divide-by-zero:
  - done is high in the cycle after the start edge.
  - div_zero=1; hi/lo unchanged from the previous result.
- Signed overflow case (MIN_INT / -1): lo=MIN_INT, hi=0; no flag is raised.
- start while busy or in DONE is ignored; no queuing.
- op and operand changes after acceptance have no effect.
- busy=1 in MUL, DIV and FINISH; 0 in IDLE and DONE.
- Back-to-back operation: start may be asserted in the cycle after done (IDLE).

Test Plan:
- WIDTH=32, MULT a=FFFFFFFD (-3), b=00000007 -> done 34 cycles after start; hi=FFFFFFFF, lo=FFFFFFEB; counter reaches 32.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Same operands with MULT -> hi=00000000, lo=00000001.
- DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1). DIVU a=00000007, b=00000002 -> lo=3, hi=1.
- DIVU a=7, b=0 after a prior result hi=1, lo=3 -> done and div_zero the cycle after start; hi=1, lo=3 retained; the next start clears div_zero.
- DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000, div_zero=0.
- Control cases:
  - start pulsed at cycle 10 of a MULT -> ignored; the result is that of the first op.
  - reset asserted at cycle 15 -> next cycle busy=0, hi=lo=0, counter=0.
  - WIDTH=8, MULT 0x80*0x80 -> hi=0x40, lo=0x00; done 10 cycles after start.
